ft60x_device: RTL and testbench

FT60X_DEVICE -- requirements
Module: ft60x_device

---
 rtl/ft60x_device.sv | 108 ++++++++++
 tb/tb_ft60x_device.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft60x_device.sv
// FT600/FT601 device-side bus model: a host-loaded DN FIFO feeds FPGA reads,
// and FPGA writes land in an UP FIFO that the host drains.
module ft60x_device #(
  parameter int BUS_WIDTH = 16,
  parameter int DN_DEPTH  = 64,
  parameter int UP_DEPTH  = 64
) (
  input  logic                   ft_clk,
  input  logic                   rst,
  inout  wire  [BUS_WIDTH-1:0]   ft_data,
  inout  wire  [BUS_WIDTH/8-1:0] ft_be,
  input  logic                   ft_oe,
  input  logic                   ft_rd,
  input  logic                   ft_wr,
  output logic                   ft_rxf,
  output logic                   ft_txe,
  input  logic [BUS_WIDTH-1:0]   host_din,
  input  logic [BUS_WIDTH/8-1:0] host_din_be,
  input  logic                   host_din_valid,
  output logic                   host_din_full,
  output logic [BUS_WIDTH-1:0]   host_dout,
  output logic [BUS_WIDTH/8-1:0] host_dout_be,
  output logic                   host_dout_valid,
  input  logic                   host_dout_ready,
  input  logic                   stall_rxf,
  input  logic                   stall_txe,
  output logic [31:0]            rd_count,
  output logic [31:0]            wr_count,
  output logic                   proto_err
);

  localparam int BE_W  = BUS_WIDTH / 8;
  localparam int EW    = BUS_WIDTH + BE_W;
  localparam int DN_AW = $clog2(DN_DEPTH);
  localparam int UP_AW = $clog2(UP_DEPTH);
  localparam logic [DN_AW:0] DN_CAP = (DN_AW+1)'(DN_DEPTH);
  localparam logic [UP_AW:0] UP_CAP = (UP_AW+1)'(UP_DEPTH);
  localparam logic [DN_AW:0] DN_ONE = (DN_AW+1)'(1);
  localparam logic [UP_AW:0] UP_ONE = (UP_AW+1)'(1);

  logic [EW-1:0]  dn_mem [DN_DEPTH];
  logic [DN_AW:0] dn_wp, dn_rp, dn_count, dn_count_nxt;
  logic [EW-1:0]  dn_head;
  logic           dn_push, dn_pop;

  logic [EW-1:0]  up_mem [UP_DEPTH];
  logic [UP_AW:0] up_wp, up_rp, up_count, up_count_nxt;
  logic [EW-1:0]  up_head;
  logic           up_push, up_pop;

  logic bus_err, seq_err, bus_drive;

  // Illegal strobe combinations block any transfer; the flag-violation cases
  // are naturally no-ops because the transfer qualifiers include ft_rxf/ft_txe.
  assign bus_err = (!ft_rd && ft_oe) || (!ft_wr && !ft_oe) || (!ft_rd && !ft_wr);
  assign seq_err = (!ft_rd && ft_rxf) || (!ft_wr && ft_txe);

  assign dn_count      = dn_wp - dn_rp;
  assign host_din_full = (dn_count == DN_CAP);
  assign dn_push       = host_din_valid && !host_din_full;
  assign dn_pop        = !ft_oe && !ft_rd && !ft_rxf && !bus_err;
  assign dn_head       = dn_mem[dn_rp[DN_AW-1:0]];
  assign dn_count_nxt  = dn_count + (DN_AW+1)'(dn_push) - (DN_AW+1)'(dn_pop);

  assign bus_drive = !ft_oe && !rst;
  assign ft_data   = bus_drive ? dn_head[BUS_WIDTH-1:0] : {BUS_WIDTH{1'bz}};
  assign ft_be     = bus_drive ? dn_head[EW-1:BUS_WIDTH] : {BE_W{1'bz}};

  assign up_count        = up_wp - up_rp;
  assign host_dout_valid = (up_count != '0);
  assign up_pop          = host_dout_valid && host_dout_ready;
  assign up_push         = ft_oe && !ft_wr && !ft_txe && !bus_err;
  assign up_head         = up_mem[up_rp[UP_AW-1:0]];
  assign host_dout       = up_head[BUS_WIDTH-1:0];
  assign host_dout_be    = up_head[EW-1:BUS_WIDTH];
  assign up_count_nxt    = up_count + (UP_AW+1)'(up_push) - (UP_AW+1)'(up_pop);

  always_ff @(posedge ft_clk or posedge rst) begin
    if (rst) begin
      dn_wp     <= '0;
      dn_rp     <= '0;
      up_wp     <= '0;
      up_rp     <= '0;
      ft_rxf    <= 1'b1;
      ft_txe    <= 1'b1;
      rd_count  <= '0;
      wr_count  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (dn_push) dn_wp <= dn_wp + DN_ONE;
      if (dn_pop)  dn_rp <= dn_rp + DN_ONE;
      if (up_push) up_wp <= up_wp + UP_ONE;
      if (up_pop)  up_rp <= up_rp + UP_ONE;
      ft_rxf <= (dn_count_nxt == '0) || stall_rxf;
      ft_txe <= (up_count_nxt == UP_CAP) || stall_txe;
      if (dn_pop)  rd_count <= rd_count + 32'd1;
      if (up_push) wr_count <= wr_count + 32'd1;
      if (bus_err || seq_err) proto_err <= 1'b1;
    end
  end

  // FIFO storage is data only; occupancy lives entirely in the pointers.
  always_ff @(posedge ft_clk) begin
    if (dn_push) dn_mem[dn_wp[DN_AW-1:0]] <= {host_din_be, host_din};
    if (up_push) up_mem[up_wp[UP_AW-1:0]] <= {ft_be, ft_data};
  end

endmodule

// File: tb/tb_ft60x_device.sv
// Self-checking bench for ft60x_device: queue scoreboard for both FIFOs plus
// vector tables for data paths and strobe-error cases.
module tb_ft60x_device;

  localparam int BW   = 16;
  localparam int BEW  = 2;
  localparam int DN_D = 8;
  localparam int UP_D = 8;

  logic            ft_clk = 1'b0;
  logic            rst;
  wire  [BW-1:0]   ft_data;
  wire  [BEW-1:0]  ft_be;
  logic            ft_oe, ft_rd, ft_wr;
  logic            ft_rxf, ft_txe;
  logic [BW-1:0]   host_din;
  logic [BEW-1:0]  host_din_be;
  logic            host_din_valid, host_din_full;
  logic [BW-1:0]   host_dout;
  logic [BEW-1:0]  host_dout_be;
  logic            host_dout_valid, host_dout_ready;
  logic            stall_rxf, stall_txe;
  logic [31:0]     rd_count, wr_count;
  logic            proto_err;
  logic [BW-1:0]   tb_data;
  logic [BEW-1:0]  tb_be;

  assign ft_data = ft_oe ? tb_data : {BW{1'bz}};
  assign ft_be   = ft_oe ? tb_be   : {BEW{1'bz}};

  ft60x_device #(.BUS_WIDTH(BW), .DN_DEPTH(DN_D), .UP_DEPTH(UP_D)) dut (
    .ft_clk(ft_clk), .rst(rst), .ft_data(ft_data), .ft_be(ft_be),
    .ft_oe(ft_oe), .ft_rd(ft_rd), .ft_wr(ft_wr), .ft_rxf(ft_rxf), .ft_txe(ft_txe),
    .host_din(host_din), .host_din_be(host_din_be), .host_din_valid(host_din_valid),
    .host_din_full(host_din_full), .host_dout(host_dout), .host_dout_be(host_dout_be),
    .host_dout_valid(host_dout_valid), .host_dout_ready(host_dout_ready),
    .stall_rxf(stall_rxf), .stall_txe(stall_txe),
    .rd_count(rd_count), .wr_count(wr_count), .proto_err(proto_err)
  );

  always #5 ft_clk = ~ft_clk;

  typedef struct {
    logic [BW-1:0]  din;
    logic [BEW-1:0] be;
    logic [BW-1:0]  exp_data;
    logic [BEW-1:0] exp_be;
  } dn_vec_t;

  typedef struct {
    logic        oe;
    logic        rd;
    logic        wr;
    logic        preload;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] exp_wr;
  } err_vec_t;

  int checks = 0;
  int errors = 0;

  logic [BW+BEW-1:0] dn_q[$];
  logic [BW+BEW-1:0] up_q[$];
  logic              m_rxf, m_txe, m_err;
  logic [31:0]       m_rd, m_wr;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".rxf"}, 64'(ft_rxf), 64'(m_rxf));
    chk({tag, ".txe"}, 64'(ft_txe), 64'(m_txe));
    chk({tag, ".rd_count"}, 64'(rd_count), 64'(m_rd));
    chk({tag, ".wr_count"}, 64'(wr_count), 64'(m_wr));
    chk({tag, ".proto_err"}, 64'(proto_err), 64'(m_err));
  endtask

  task automatic idle_inputs();
    ft_oe = 1'b1; ft_rd = 1'b1; ft_wr = 1'b1;
    host_din = '0; host_din_be = '0; host_din_valid = 1'b0;
    host_dout_ready = 1'b0; stall_rxf = 1'b0; stall_txe = 1'b0;
    tb_data = '0; tb_be = '0;
  endtask

  task automatic model_reset();
    dn_q.delete(); up_q.delete();
    m_rxf = 1'b1; m_txe = 1'b1; m_err = 1'b0; m_rd = '0; m_wr = '0;
  endtask

  // One bus cycle: predict transfers from the inputs already applied, score
  // the words leaving each FIFO, then advance past the clock edge.
  task automatic cycle();
    logic berr, pop, upush, dpush, upop;
    logic [BW+BEW-1:0] exp;
    #1;
    berr  = (!ft_rd && ft_oe) || (!ft_wr && !ft_oe) || (!ft_rd && !ft_wr);
    pop   = !ft_oe && !ft_rd && !m_rxf && !berr;
    upush = ft_oe && !ft_wr && !m_txe && !berr;
    dpush = host_din_valid && (dn_q.size() < DN_D);
    upop  = host_dout_ready && (up_q.size() != 0);
    if (pop) begin
      exp = dn_q.pop_front();
      chk("dn_word", 64'({ft_be, ft_data}), 64'(exp));
    end
    if (upop) begin
      exp = up_q.pop_front();
      chk("up_word", 64'({host_dout_be, host_dout}), 64'(exp));
    end
    if (dpush) dn_q.push_back({host_din_be, host_din});
    if (upush) up_q.push_back({tb_be, tb_data});
    if (berr || (!ft_rd && m_rxf) || (!ft_wr && m_txe)) m_err = 1'b1;
    if (pop)   m_rd = m_rd + 32'd1;
    if (upush) m_wr = m_wr + 32'd1;
    @(posedge ft_clk);
    m_rxf = (dn_q.size() == 0) || stall_rxf;
    m_txe = (up_q.size() == UP_D) || stall_txe;
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge ft_clk);
    @(posedge ft_clk);
    #1;
    rst = 1'b0;
    cycle();
  endtask

  task automatic host_load(input logic [BW-1:0] d, input logic [BEW-1:0] be);
    host_din = d; host_din_be = be; host_din_valid = 1'b1;
    cycle();
    host_din_valid = 1'b0;
  endtask

  dn_vec_t  tbl [8];
  err_vec_t ev  [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h0001, 2'b11, 16'h0001, 2'b11};
    tbl[1] = '{16'h8000, 2'b01, 16'h8000, 2'b01};
    tbl[2] = '{16'hFFFF, 2'b10, 16'hFFFF, 2'b10};
    tbl[3] = '{16'h1234, 2'b11, 16'h1234, 2'b11};
    tbl[4] = '{16'hA5A5, 2'b00, 16'hA5A5, 2'b00};
    tbl[5] = '{16'h5A5A, 2'b11, 16'h5A5A, 2'b11};
    tbl[6] = '{16'h0F0F, 2'b01, 16'h0F0F, 2'b01};
    tbl[7] = '{16'hC3C3, 2'b10, 16'hC3C3, 2'b10};

    // oe rd wr preload exp_err exp_rd exp_wr
    ev[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0};
    ev[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 32'd0};
    ev[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0};
    ev[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0};
    ev[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0};
    ev[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0};
    ev[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1, 32'd0};
    ev[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd1};
    ev[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0};

    idle_inputs();
    model_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    @(posedge ft_clk);
    @(posedge ft_clk);
    #1;
    chk("rst.rxf", 64'(ft_rxf), 64'd1);
    chk("rst.txe", 64'(ft_txe), 64'd1);
    chk("rst.rd_count", 64'(rd_count), 64'd0);
    chk("rst.wr_count", 64'(wr_count), 64'd0);
    chk("rst.proto_err", 64'(proto_err), 64'd0);
    chk("rst.din_full", 64'(host_din_full), 64'd0);
    chk("rst.dout_valid", 64'(host_dout_valid), 64'd0);
    rst = 1'b0;
    cycle();
    chk("rst_release.txe", 64'(ft_txe), 64'd0);
    chk("rst_release.rxf", 64'(ft_rxf), 64'd1);

    // Three-word read burst with a one-cycle oe turnaround.
    host_load(16'h1111, 2'b11);
    host_load(16'h2222, 2'b11);
    host_load(16'h3333, 2'b11);
    ft_oe = 1'b0;
    cycle();
    ft_rd = 1'b0;
    repeat (3) cycle();
    chk("burst3.rxf", 64'(ft_rxf), 64'd1);
    chk("burst3.rd_count", 64'(rd_count), 64'd3);
    ft_rd = 1'b1; ft_oe = 1'b1;
    cycle();
    chk("burst3.proto_err", 64'(proto_err), 64'd0);
    chk_state("burst3");

    // DN table: fill to full, drop a write while full, then drain with a
    // dropped push at full and an accepted push coinciding with a pop.
    do_reset();
    for (int i = 0; i < DN_D; i++) host_load(tbl[i].din, tbl[i].be);
    chk("dn.full", 64'(host_din_full), 64'd1);
    host_load(16'hDEAD, 2'b11);
    chk("dn.full_after_drop", 64'(host_din_full), 64'd1);
    ft_oe = 1'b0;
    cycle();
    for (int i = 0; i < DN_D; i++) begin
      ft_rd = 1'b0;
      if (i == 0) begin host_din = 16'hBEEF; host_din_be = 2'b11; host_din_valid = 1'b1; end
      if (i == 3) begin host_din = 16'h7777; host_din_be = 2'b10; host_din_valid = 1'b1; end
      #1;
      chk($sformatf("dn_tbl%0d.data", i), 64'(ft_data), 64'(tbl[i].exp_data));
      chk($sformatf("dn_tbl%0d.be", i), 64'(ft_be), 64'(tbl[i].exp_be));
      cycle();
      host_din_valid = 1'b0;
    end
    cycle();
    ft_rd = 1'b1; ft_oe = 1'b1;
    chk("dn.rd_count", 64'(rd_count), 64'd9);
    chk("dn.rxf_empty", 64'(ft_rxf), 64'd1);
    chk_state("dn");

    // Strobe-combination table, each from a fresh reset.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      if (ev[i].preload) host_load(16'h1234, 2'b11);
      ft_oe = ev[i].oe; ft_rd = ev[i].rd; ft_wr = ev[i].wr;
      tb_data = 16'h4321; tb_be = 2'b01;
      cycle();
      idle_inputs();
      cycle();
      chk($sformatf("err%0d.proto_err", i), 64'(proto_err), 64'(ev[i].exp_err));
      chk($sformatf("err%0d.rd_count", i), 64'(rd_count), 64'(ev[i].exp_rd));
      chk($sformatf("err%0d.wr_count", i), 64'(wr_count), 64'(ev[i].exp_wr));
    end

    // Write burst longer than the UP FIFO.
    do_reset();
    tb_data = 16'hA5A5; tb_be = 2'b11; ft_wr = 1'b0;
    repeat (UP_D + 2) cycle();
    ft_wr = 1'b1;
    chk("upfill.wr_count", 64'(wr_count), 64'(UP_D));
    chk("upfill.txe", 64'(ft_txe), 64'd1);
    chk("upfill.proto_err", 64'(proto_err), 64'd1);
    chk_state("upfill");

    // Full UP: host drain and FPGA write in the same cycle; the write is refused.
    host_dout_ready = 1'b1; ft_wr = 1'b0;
    cycle();
    ft_wr = 1'b1; host_dout_ready = 1'b0;
    chk("upfull.wr_count", 64'(wr_count), 64'(UP_D));
    chk_state("upfull");
    host_dout_ready = 1'b1;
    repeat (UP_D - 1) cycle();
    host_dout_ready = 1'b0;
    chk("upfull.drained", 64'(host_dout_valid), 64'd0);

    // UP table loopback: bus writes come out on host_dout in order.
    for (int i = 0; i < UP_D; i++) begin
      ft_wr = 1'b0; tb_data = tbl[i].din; tb_be = tbl[i].be;
      cycle();
    end
    ft_wr = 1'b1;
    for (int i = 0; i < UP_D; i++) begin
      host_dout_ready = 1'b1;
      #1;
      chk($sformatf("up_tbl%0d.data", i), 64'(host_dout), 64'(tbl[i].exp_data));
      chk($sformatf("up_tbl%0d.be", i), 64'(host_dout_be), 64'(tbl[i].exp_be));
      cycle();
    end
    host_dout_ready = 1'b0;
    chk_state("up_tbl");

    // oe and wr low together: device keeps driving, nothing is pushed.
    do_reset();
    host_load(16'h5A5A, 2'b01);
    ft_oe = 1'b0; ft_wr = 1'b0; tb_data = 16'h9999;
    #1;
    chk("oe_wr.bus_data", 64'(ft_data), 64'h5A5A);
    chk("oe_wr.bus_be", 64'(ft_be), 64'h1);
    cycle();
    idle_inputs();
    cycle();
    chk("oe_wr.proto_err", 64'(proto_err), 64'd1);
    chk("oe_wr.wr_count", 64'(wr_count), 64'd0);
    chk("oe_wr.rxf", 64'(ft_rxf), 64'd0);
    chk_state("oe_wr");

    // Throttling inputs.
    do_reset();
    host_load(16'h0BAD, 2'b11);
    chk("stall.rxf_before", 64'(ft_rxf), 64'd0);
    stall_rxf = 1'b1;
    cycle();
    chk("stall.rxf_forced", 64'(ft_rxf), 64'd1);
    stall_rxf = 1'b0;
    cycle();
    chk("stall.rxf_release", 64'(ft_rxf), 64'd0);
    stall_txe = 1'b1;
    cycle();
    chk("stall.txe_forced", 64'(ft_txe), 64'd1);
    stall_txe = 1'b0;
    cycle();
    chk("stall.txe_release", 64'(ft_txe), 64'd0);
    chk_state("stall");

    // Reset pulse in the middle of a four-word read burst.
    do_reset();
    for (int i = 0; i < 4; i++) host_load(tbl[i].din, tbl[i].be);
    ft_oe = 1'b0;
    cycle();
    ft_rd = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    #2;
    chk("midrst.rxf", 64'(ft_rxf), 64'd1);
    chk("midrst.txe", 64'(ft_txe), 64'd1);
    chk("midrst.rd_count", 64'(rd_count), 64'd0);
    chk("midrst.wr_count", 64'(wr_count), 64'd0);
    chk("midrst.proto_err", 64'(proto_err), 64'd0);
    chk("midrst.din_full", 64'(host_din_full), 64'd0);
    chk("midrst.dout_valid", 64'(host_dout_valid), 64'd0);
    idle_inputs();
    model_reset();
    @(posedge ft_clk);
    #1;
    rst = 1'b0;
    cycle();
    chk("midrst.dn_empty", 64'(ft_rxf), 64'd1);
    chk_state("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
